// File: rtl/hdmi_audio_pkg.sv
// Shared constants and source-select encodings for the HDMI audio sample scheduler.
package hdmi_audio_pkg;

  localparam int ACC_W = 32;

  typedef enum logic [1:0] {
    SRC_TONE   = 2'd0,
    SRC_STREAM = 2'd1,
    SRC_AUTO   = 2'd2
  } src_e;

  // The reserved encoding falls back to the test tone.
  function automatic src_e decode_src(input logic [1:0] sel);
    case (sel)
      2'd1:    return SRC_STREAM;
      2'd2:    return SRC_AUTO;
      default: return SRC_TONE;
    endcase
  endfunction

endpackage

// File: rtl/hdmi_audio_fifo.sv
// Small synchronous FIFO for the external L/R stream; no fall-through, pop never frees a same-cycle push.
module hdmi_audio_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk_pixel,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rptr];
  assign level   = count;

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wptr] <= din;
        wptr      <= wptr + 1'b1;
      end
      if (do_pop) rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/hdmi_audio_sample_scheduler.sv
// Paces audio samples into the HDMI core with a fractional accumulator and
// selects between a sawtooth test tone and a buffered external stream.
module hdmi_audio_sample_scheduler
  import hdmi_audio_pkg::*;
#(
  parameter int unsigned PIXEL_CLK_HZ = 25200000,
  parameter int unsigned AUDIO_RATE   = 48000,
  parameter int          BIT_WIDTH    = 16,
  parameter int          FIFO_DEPTH   = 4,
  parameter int unsigned TONE_STEP_L  = 8,
  parameter int unsigned TONE_STEP_R  = 32
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          enable,
  input  logic                          mute,
  input  logic [1:0]                    src_sel,
  input  logic                          s_valid,
  output logic                          s_ready,
  input  logic [BIT_WIDTH-1:0]          s_left,
  input  logic [BIT_WIDTH-1:0]          s_right,
  output logic                          sample_tick,
  output logic                          clk_audio,
  output logic [2*BIT_WIDTH-1:0]        audio_sample_word,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   underrun_count
);

  localparam logic [ACC_W:0]       RATE_X = (ACC_W + 1)'(AUDIO_RATE);
  localparam logic [ACC_W:0]       PIX_X  = (ACC_W + 1)'(PIXEL_CLK_HZ);
  localparam logic [ACC_W-1:0]     HALF   = ACC_W'(PIXEL_CLK_HZ / 2);
  localparam logic [BIT_WIDTH-1:0] STEP_L = BIT_WIDTH'(TONE_STEP_L);
  localparam logic [BIT_WIDTH-1:0] STEP_R = BIT_WIDTH'(TONE_STEP_R);

  logic [ACC_W-1:0]       acc;
  logic [ACC_W-1:0]       acc_next;
  logic [ACC_W:0]         acc_sum;
  logic [ACC_W:0]         acc_wrap;
  logic                   tick;
  logic                   tick_d;
  logic                   clk_q;
  logic [BIT_WIDTH-1:0]   tone_l;
  logic [BIT_WIDTH-1:0]   tone_r;
  logic [BIT_WIDTH-1:0]   tone_l_next;
  logic [BIT_WIDTH-1:0]   tone_r_next;
  logic [2*BIT_WIDTH-1:0] word;
  logic [15:0]            underrun_q;
  src_e                   src;
  logic                   take_stream;
  logic                   take_tone;
  logic                   underrun;
  logic [2*BIT_WIDTH-1:0] fifo_dout;
  logic                   fifo_full;
  logic                   fifo_empty;

  always_comb begin
    acc_sum  = {1'b0, acc} + RATE_X;
    acc_wrap = acc_sum - PIX_X;
    tick     = enable && (acc_sum >= PIX_X);
    acc_next = acc_sum[ACC_W-1:0];
    if (!enable)  acc_next = '0;
    else if (tick) acc_next = acc_wrap[ACC_W-1:0];
  end

  // src_sel is only acted on in the tick cycle, so it needs no extra capture register.
  always_comb begin
    src         = decode_src(src_sel);
    take_stream = tick && (src != SRC_TONE) && !fifo_empty;
    take_tone   = tick && ((src == SRC_TONE) || ((src == SRC_AUTO) && fifo_empty));
    underrun    = tick && (src == SRC_STREAM) && fifo_empty;
    tone_l_next = tone_l + STEP_L;
    tone_r_next = tone_r - STEP_R;
  end

  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      acc        <= '0;
      tick_d     <= 1'b0;
      clk_q      <= 1'b0;
      tone_l     <= '0;
      tone_r     <= '0;
      word       <= '0;
      underrun_q <= '0;
    end else begin
      acc    <= acc_next;
      tick_d <= tick;
      if (take_tone) begin
        tone_l <= tone_l_next;
        tone_r <= tone_r_next;
      end
      if (tick) begin
        if (mute)             word <= '0;
        else if (take_stream) word <= fifo_dout;
        else if (take_tone)   word <= {tone_l_next, tone_r_next};
        else                  word <= '0;
      end
      if (underrun && (underrun_q != 16'hFFFF)) underrun_q <= underrun_q + 16'd1;
      // Rise one cycle after the word lands; fall once the accumulator passes mid-period.
      if (!enable)                          clk_q <= 1'b0;
      else if (tick_d)                      clk_q <= 1'b1;
      else if (clk_q && (acc_next >= HALF)) clk_q <= 1'b0;
    end
  end

  hdmi_audio_fifo #(
    .WIDTH (2 * BIT_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_pixel (clk_pixel),
    .reset     (reset),
    .push      (s_valid),
    .pop       (take_stream),
    .din       ({s_left, s_right}),
    .dout      (fifo_dout),
    .level     (fifo_level),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign s_ready           = !fifo_full;
  assign sample_tick       = tick;
  assign clk_audio         = clk_q;
  assign audio_sample_word = word;
  assign underrun_count    = underrun_q;

endmodule

// File: tb/tb_hdmi_audio_sample_scheduler.sv
// Directed bench for the HDMI audio sample scheduler at 480 Hz / 48 Hz (one tick per 10 cycles).
module tb_hdmi_audio_sample_scheduler;

  logic        clk_pixel;
  logic        reset;
  logic        enable;
  logic        mute;
  logic [1:0]  src_sel;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_left;
  logic [15:0] s_right;
  logic        sample_tick;
  logic        clk_audio;
  logic [31:0] audio_sample_word;
  logic [2:0]  fifo_level;
  logic [15:0] underrun_count;

  int vectors = 0;
  int errors  = 0;
  int n;

  hdmi_audio_sample_scheduler #(
    .PIXEL_CLK_HZ (480),
    .AUDIO_RATE   (48),
    .BIT_WIDTH    (16),
    .FIFO_DEPTH   (4),
    .TONE_STEP_L  (8),
    .TONE_STEP_R  (32)
  ) dut (
    .clk_pixel         (clk_pixel),
    .reset             (reset),
    .enable            (enable),
    .mute              (mute),
    .src_sel           (src_sel),
    .s_valid           (s_valid),
    .s_ready           (s_ready),
    .s_left            (s_left),
    .s_right           (s_right),
    .sample_tick       (sample_tick),
    .clk_audio         (clk_audio),
    .audio_sample_word (audio_sample_word),
    .fifo_level        (fifo_level),
    .underrun_count    (underrun_count)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  // Steps until sample_tick is seen; returns the step count (21 if it never came).
  task automatic wait_tick(output int cnt);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!sample_tick && cnt <= 20);
  endtask

  task automatic push_sample(input logic [15:0] l, input logic [15:0] r);
    s_valid = 1'b1;
    s_left  = l;
    s_right = r;
    step();
    s_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b1; enable = 1'b1; mute = 1'b0; src_sel = 2'd0;
    s_valid = 1'b0; s_left = '0; s_right = '0;
    repeat (3) step();

    // reset state
    chk("rst_tick",     32'(sample_tick), 0);
    chk("rst_clk",      32'(clk_audio), 0);
    chk("rst_word",     audio_sample_word, 0);
    chk("rst_level",    32'(fifo_level), 0);
    chk("rst_ready",    32'(s_ready), 1);
    chk("rst_underrun", 32'(underrun_count), 0);

    // 1: tone pacing and clk_audio shape
    reset = 1'b0;
    wait_tick(n);
    chk("t1_first_tick", n, 9);
    step();
    chk("t1_word1", audio_sample_word, 32'h0008FFE0);
    chk("t1_clk_low", 32'(clk_audio), 0);
    step();
    chk("t1_clk_rise", 32'(clk_audio), 1);
    repeat (3) step();
    chk("t1_clk_high", 32'(clk_audio), 1);
    step();
    chk("t1_clk_fall", 32'(clk_audio), 0);
    wait_tick(n);
    chk("t1_period", n, 4);
    step();
    chk("t1_word2", audio_sample_word, 32'h0010FFC0);

    // 2: stream fill, back-pressure, ordered drain
    enable = 1'b0; src_sel = 2'd1;
    for (int i = 1; i <= 4; i++) push_sample(16'(i), 16'(i + 1));
    chk("t2_level_full", 32'(fifo_level), 4);
    chk("t2_ready_low", 32'(s_ready), 0);
    push_sample(16'd5, 16'd6);
    chk("t2_refused", 32'(fifo_level), 4);
    enable = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      wait_tick(n);
      chk("t2_period", n, 9);
      step();
      chk("t2_word", audio_sample_word, {16'(i), 16'(i + 1)});
      chk("t2_level", 32'(fifo_level), 32'(4 - i));
      if (i == 1) chk("t2_ready_back", 32'(s_ready), 1);
    end

    // 3: underruns and saturation
    for (int k = 1; k <= 3; k++) begin
      wait_tick(n);
      step();
      chk("t3_word_zero", audio_sample_word, 0);
      chk("t3_underrun", 32'(underrun_count), 32'(k));
    end
    force dut.underrun_q = 16'hFFFF;
    step();
    release dut.underrun_q;
    #1;
    chk("t3_preload", 32'(underrun_count), 32'h0000FFFF);
    wait_tick(n);
    chk("t3_period", n, 8);
    step();
    chk("t3_saturate", 32'(underrun_count), 32'h0000FFFF);

    // 4: auto mode, stream then tone
    reset = 1'b1;
    step();
    reset = 1'b0; enable = 1'b0; src_sel = 2'd2;
    push_sample(16'hAAAA, 16'h5555);
    chk("t4_level", 32'(fifo_level), 1);
    enable = 1'b1;
    wait_tick(n);
    chk("t4_period", n, 9);
    step();
    chk("t4_word_stream", audio_sample_word, 32'hAAAA5555);
    wait_tick(n);
    step();
    chk("t4_word_tone", audio_sample_word, 32'h0008FFE0);
    chk("t4_underrun", 32'(underrun_count), 0);

    // 5: mute keeps popping and tone advancing
    enable = 1'b0; src_sel = 2'd1; mute = 1'b1;
    push_sample(16'd7, 16'd8);
    push_sample(16'd9, 16'd10);
    enable = 1'b1;
    wait_tick(n);
    step();
    chk("t5_mute_word1", audio_sample_word, 0);
    chk("t5_level1", 32'(fifo_level), 1);
    wait_tick(n);
    step();
    chk("t5_mute_word2", audio_sample_word, 0);
    chk("t5_level0", 32'(fifo_level), 0);
    src_sel = 2'd0;
    wait_tick(n);
    step();
    chk("t5_mute_tone", audio_sample_word, 0);
    mute = 1'b0;
    wait_tick(n);
    step();
    chk("t5_tone_advanced", audio_sample_word, 32'h0018FFA0);
    chk("t5_underrun", 32'(underrun_count), 0);

    // 6: reset mid-period
    enable = 1'b0;
    for (int i = 0; i < 3; i++) push_sample(16'(16'h100 + i), 16'(16'h200 + i));
    enable = 1'b1;
    wait_tick(n);
    step();
    step();
    chk("t6_pre_clk", 32'(clk_audio), 1);
    chk("t6_pre_level", 32'(fifo_level), 3);
    reset = 1'b1;
    #1;
    chk("t6_clk", 32'(clk_audio), 0);
    chk("t6_word", audio_sample_word, 0);
    chk("t6_level", 32'(fifo_level), 0);
    chk("t6_ready", 32'(s_ready), 1);
    chk("t6_tick", 32'(sample_tick), 0);
    chk("t6_underrun", 32'(underrun_count), 0);
    step();
    reset = 1'b0;
    wait_tick(n);
    chk("t6_first_tick", n, 9);
    step();
    chk("t6_word_after", audio_sample_word, 32'h0008FFE0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
